output_result_fifo: RTL and testbench

- Buffering stage directly downstream of the convolution controller and output data shifter (ODS).
- The controller asserts `output_valid` with x/y/ch coordinates for up to 3 consecutive cycles per pixel and cannot stall. This block captures each result word with its coordinates into a small FIFO.
- It re-presents the words to the external host with a valid/ready handshake, absorbing host backpressure.
- `almost_full` lets the controller hold in a load state before the next compute burst. Overflow is flagged, never silently hidden.

---
 rtl/output_result_fifo.sv | 103 ++++++++++
 tb/tb_output_result_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/output_result_fifo.sv
// Result buffer between the convolution controller/ODS and the host: captures
// {data, x, y, ch} words that cannot be stalled and re-presents them in order.
module output_result_fifo #(
  parameter int DATA_WIDTH        = 32,
  parameter int COORD_WIDTH       = 32,
  parameter int DEPTH             = 8,
  parameter int ALMOST_FULL_LEVEL = 5
) (
  input  logic                       clk,
  input  logic                       arst_n_in,
  input  logic                       clear,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [COORD_WIDTH-1:0]     in_x,
  input  logic [COORD_WIDTH-1:0]     in_y,
  input  logic [COORD_WIDTH-1:0]     in_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [COORD_WIDTH-1:0]     out_x,
  output logic [COORD_WIDTH-1:0]     out_y,
  output logic [COORD_WIDTH-1:0]     out_ch,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       almost_full,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = DATA_WIDTH + 3 * COORD_WIDTH;

  // Output handshake: a word transfers on a rising edge where out_valid and
  // out_ready are both high; while out_valid is high and no transfer happens,
  // out_data/x/y/ch hold their value. The input side has no ready at all.

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] head;

  assign full = (count_q == CW'(DEPTH));
  assign pop  = out_valid && out_ready && !clear;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push = in_valid && !clear && (!full || pop);
  assign drop = in_valid && !clear && !push;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (drop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; every read is gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_data, in_x, in_y, in_ch};
  end

  assign out_valid = (count_q != '0);
  assign head      = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_data    = head[EW-1 -: DATA_WIDTH];
  assign out_x       = head[3*COORD_WIDTH-1 -: COORD_WIDTH];
  assign out_y       = head[2*COORD_WIDTH-1 -: COORD_WIDTH];
  assign out_ch      = head[COORD_WIDTH-1:0];
  assign count       = count_q;
  assign almost_full = (count_q >= CW'(ALMOST_FULL_LEVEL));
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_output_result_fifo.sv
// Directed bench for output_result_fifo with hand-computed expected values.
module tb_output_result_fifo;

  localparam int DW = 32;
  localparam int CWD = 32;

  logic          clk = 1'b0;
  logic          arst_n_in;
  logic          clear;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CWD-1:0] in_x, in_y, in_ch;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CWD-1:0] out_x, out_y, out_ch;
  logic [3:0]    count;
  logic          almost_full;
  logic          overflow;

  int n_checks = 0;
  int n_errors = 0;

  output_result_fifo dut (
    .clk        (clk),
    .arst_n_in  (arst_n_in),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_ch      (in_ch),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_ch     (out_ch),
    .count      (count),
    .almost_full(almost_full),
    .overflow   (overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 ns after the active edge, outputs sampled there too
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d, input int x, input int ch);
    in_valid = v;
    in_data  = DW'(d);
    in_x     = CWD'(x);
    in_y     = CWD'(x + 1);
    in_ch    = CWD'(ch);
  endtask

  initial begin
    arst_n_in = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 0, 0, 0);
    repeat (2) @(negedge clk);
    arst_n_in = 1'b1;
    tick();

    // reset state
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_count", count, 0);
    check_val("rst_almost_full", almost_full, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_out_data", out_data, 0);

    // 3-word burst with the host always ready
    out_ready = 1'b1;
    drive(1'b1, 10, 0, 0);
    check_val("burst_no_bypass", out_valid, 0);
    tick();
    check_val("burst_valid_c2", out_valid, 1);
    check_val("burst_d0", out_data, 10);
    check_val("burst_ch0", out_ch, 0);
    drive(1'b1, 11, 0, 1);
    tick();
    check_val("burst_d1", out_data, 11);
    check_val("burst_ch1", out_ch, 1);
    check_val("burst_cnt1", count, 1);
    drive(1'b1, 12, 0, 2);
    tick();
    check_val("burst_d2", out_data, 12);
    check_val("burst_ch2", out_ch, 2);
    drive(1'b0, 0, 0, 0);
    tick();
    check_val("burst_empty_cnt", count, 0);
    check_val("burst_empty_valid", out_valid, 0);
    check_val("burst_overflow", overflow, 0);

    // backpressure: 5 pushes, then 4 more into DEPTH 8
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 100 + i, i, i % 3);
      tick();
      if (i == 3) check_val("bp_af_at4", almost_full, 0);
      if (i == 4) begin
        check_val("bp_cnt5", count, 5);
        check_val("bp_af_at5", almost_full, 1);
        check_val("bp_head5", out_data, 100);
      end
      if (i == 7) check_val("bp_ovf_at8", overflow, 0);
    end
    drive(1'b0, 0, 0, 0);
    check_val("ovf_cnt", count, 8);
    check_val("ovf_flag", overflow, 1);
    tick();
    check_val("bp_head_stable", out_data, 100);
    check_val("bp_head_x", out_x, 0);
    check_val("bp_head_y", out_y, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_val("ovf_drain", out_data, 100 + i);
      check_val("ovf_drain_x", out_x, i);
      tick();
    end
    check_val("ovf_word9_absent", out_valid, 0);
    check_val("ovf_sticky", overflow, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("clr_ovf", overflow, 0);

    // full with simultaneous push/pop across pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 200 + i, i, 0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 208 + k, 8 + k, 0);
      check_val("full_pp_head", out_data, 200 + k);
      tick();
      check_val("full_pp_cnt", count, 8);
      check_val("full_pp_ovf", overflow, 0);
    end
    drive(1'b0, 0, 0, 0);
    for (int i = 4; i < 12; i++) begin
      check_val("wrap_drain", out_data, 200 + i);
      tick();
    end
    check_val("wrap_empty", count, 0);

    // clear with 6 entries, overflow set and in_valid high
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 300 + i, i, 0);
      tick();
    end
    drive(1'b0, 0, 0, 0);
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    check_val("pre_clr_cnt", count, 6);
    check_val("pre_clr_ovf", overflow, 1);
    clear = 1'b1;
    drive(1'b1, 999, 9, 9);
    tick();
    clear = 1'b0;
    drive(1'b0, 0, 0, 0);
    check_val("clr_cnt", count, 0);
    check_val("clr_valid", out_valid, 0);
    check_val("clr_ovf2", overflow, 0);
    check_val("clr_af", almost_full, 0);
    tick();
    check_val("clr_word_dropped", count, 0);

    // asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 400 + i, i, i);
      tick();
    end
    drive(1'b0, 0, 0, 0);
    out_ready = 1'b1;
    tick();
    check_val("mid_cnt", count, 2);
    check_val("mid_head", out_data, 401);
    arst_n_in = 1'b0;
    #1;
    check_val("arst_valid", out_valid, 0);
    check_val("arst_data", out_data, 0);
    check_val("arst_ch", out_ch, 0);
    check_val("arst_cnt", count, 0);
    @(negedge clk);
    arst_n_in = 1'b1;
    out_ready = 1'b0;
    #1;
    drive(1'b1, 7, 3, 1);
    tick();
    drive(1'b0, 0, 0, 0);
    check_val("post_rst_data", out_data, 7);
    check_val("post_rst_cnt", count, 1);
    out_ready = 1'b1;
    tick();
    check_val("post_rst_sole", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
